// File: rtl/subband_serializer.sv
// rtl/subband_serializer.sv - 2-slot ping-pong vector buffer streaming samples serially with index/ss tags
//
// Purpose: accepts one NUM_SAMPLES-wide subband vector per handshake into a
// two-entry ping-pong buffer and emits its samples one per cycle under
// valid/ready backpressure, tagged with sample index and granule slot (ss).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   data_in, data_valid_in   parallel vector input and its valid
//   ready_out                a vector slot is free (registered)
//   data_out, data_valid_out serial sample and its valid (registered)
//   data_ready_in            downstream accepts the current sample
//   sample_idx_out, ss_out   index of data_out within its vector, granule slot
//   last_out                 current sample is the last of its vector
//   granule_last_out         last sample of the last vector of a granule
//   overflow_out             sticky: a vector was offered while both slots were full
//
// Configuration: define PCM16_SAT_EN to emit sign-extended, saturated 16-bit PCM
// (sample >>> FRAC_BITS clamped to [-32768, 32767]) instead of the raw sample.

module subband_serializer #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int NUM_SAMPLES  = 32,
  parameter int NUM_SS       = 18,
  parameter int FRAC_BITS    = 15
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0] data_in,
  input  logic                                     data_valid_in,
  output logic                                     ready_out,
  output logic [SAMPLE_WIDTH-1:0]                  data_out,
  output logic                                     data_valid_out,
  input  logic                                     data_ready_in,
  output logic [4:0]                               sample_idx_out,
  output logic [4:0]                               ss_out,
  output logic                                     last_out,
  output logic                                     granule_last_out,
  output logic                                     overflow_out
);

  localparam logic [4:0] IDX_LAST = 5'(NUM_SAMPLES - 1);
  localparam logic [4:0] SS_LAST  = 5'(NUM_SS - 1);
  localparam logic signed [SAMPLE_WIDTH-1:0] PCM_MAX = 32767;
  localparam logic signed [SAMPLE_WIDTH-1:0] PCM_MIN = -32768;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_next;

  logic [SAMPLE_WIDTH-1:0] mem [2][NUM_SAMPLES];
  logic [1:0] full, full_next;
  logic       wr_ptr, rd_ptr;
  logic       accept, transfer;
  logic       load, advance_vec, go_idle;
  logic       sel_slot;
  logic [4:0] sel_idx, ss_sel, ss_inc;
  logic [SAMPLE_WIDTH-1:0] sample_next;

  function automatic logic [SAMPLE_WIDTH-1:0] pcm16(input logic [SAMPLE_WIDTH-1:0] s);
    logic signed [SAMPLE_WIDTH-1:0] sh;
    sh = $signed(s) >>> FRAC_BITS;
    if (sh > PCM_MAX)      return PCM_MAX;
    else if (sh < PCM_MIN) return PCM_MIN;
    else                   return sh;
  endfunction

  assign accept   = data_valid_in && ready_out;
  assign transfer = data_valid_out && data_ready_in;
  assign ss_inc   = (ss_out == SS_LAST) ? 5'd0 : ss_out + 5'd1;

`ifdef PCM16_SAT_EN
  assign sample_next = pcm16(mem[sel_slot][sel_idx]);
`else
  assign sample_next = mem[sel_slot][sel_idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Decides what the output register loads next. Slots are consumed in FIFO
  // order, so whenever any slot is full, rd_ptr points at the oldest one.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    advance_vec = 1'b0;
    go_idle     = 1'b0;
    sel_slot    = rd_ptr;
    sel_idx     = sample_idx_out;
    ss_sel      = ss_out;
    case (state)
      IDLE: begin
        if (full[rd_ptr]) begin
          state_next = STREAM;
          load       = 1'b1;
          sel_idx    = 5'd0;
        end
      end
      STREAM: begin
        if (transfer) begin
          if (sample_idx_out == IDX_LAST) begin
            advance_vec = 1'b1;
            ss_sel      = ss_inc;
            // Only a slot full before this edge may follow without a bubble.
            if (full[~rd_ptr]) begin
              load     = 1'b1;
              sel_slot = ~rd_ptr;
              sel_idx  = 5'd0;
            end else begin
              state_next = IDLE;
              go_idle    = 1'b1;
            end
          end else begin
            load    = 1'b1;
            sel_idx = sample_idx_out + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    full_next = full;
    if (advance_vec) full_next[rd_ptr] = 1'b0;
    if (accept)      full_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_SAMPLES; i++) mem[wr_ptr][i] <= data_in[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full             <= 2'b00;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      ready_out        <= 1'b1;
      data_out         <= '0;
      data_valid_out   <= 1'b0;
      sample_idx_out   <= 5'd0;
      ss_out           <= 5'd0;
      last_out         <= 1'b0;
      granule_last_out <= 1'b0;
      overflow_out     <= 1'b0;
    end else begin
      full      <= full_next;
      ready_out <= ~&full_next;
      if (accept) wr_ptr <= ~wr_ptr;
      if (data_valid_in && !ready_out) overflow_out <= 1'b1;
      if (advance_vec) begin
        rd_ptr <= ~rd_ptr;
        ss_out <= ss_inc;
      end
      if (load) begin
        data_out         <= sample_next;
        data_valid_out   <= 1'b1;
        sample_idx_out   <= sel_idx;
        last_out         <= (sel_idx == IDX_LAST);
        granule_last_out <= (sel_idx == IDX_LAST) && (ss_sel == SS_LAST);
      end else if (go_idle) begin
        data_valid_out   <= 1'b0;
        sample_idx_out   <= 5'd0;
        last_out         <= 1'b0;
        granule_last_out <= 1'b0;
      end
    end
  end

endmodule
